// File: rtl/vex_dbus_responder.sv
// vex_dbus_responder: memory-backed responder for a VexRiscv-style dBus.
//
// Writes merge the addressed byte lanes into a word array and never respond.
// Reads sample the whole word at acceptance and queue it in a small response
// FIFO. The head of the FIFO is released once it has waited LATENCY cycles.
// rsp_stall holds back responses.
//
// Optional feature: define VEX_DBUS_RESP_ERROR_EN to flag accesses above the
// memory window as errors. Such writes are dropped. Such reads return error=1
// and data=0. Without the macro, upper address bits alias and the error flag
// is always 0.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   dBus_cmd_valid/ready       command handshake
//   dBus_cmd_payload_wr        1 = write, 0 = read
//   dBus_cmd_payload_address   byte address
//   dBus_cmd_payload_data      write data, byte-lane aligned
//   dBus_cmd_payload_size      log2 of access size in bytes (3 acts as 2)
//   dBus_rsp_ready             one-cycle read-response strobe
//   dBus_rsp_data/error        response payload, zero when no response
//   rsp_stall                  blocks response issue while high
module vex_dbus_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned MAX_PENDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dBus_cmd_valid,
    output logic        dBus_cmd_ready,
    input  logic        dBus_cmd_payload_wr,
    input  logic [31:0] dBus_cmd_payload_address,
    input  logic [31:0] dBus_cmd_payload_data,
    input  logic [1:0]  dBus_cmd_payload_size,
    output logic        dBus_rsp_ready,
    output logic [31:0] dBus_rsp_data,
    output logic        dBus_rsp_error,
    input  logic        rsp_stall
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam int unsigned PTRW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned CNTW = $clog2(MAX_PENDING + 1);

    localparam logic [3:0]      LAT      = 4'(LATENCY);
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(MAX_PENDING - 1);
    localparam logic [CNTW-1:0] MAX_CNT  = CNTW'(MAX_PENDING);

    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     fifo_data [MAX_PENDING];
    logic            fifo_err  [MAX_PENDING];
    logic [3:0]      fifo_age  [MAX_PENDING];
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_next;
    logic            cmd_ready_q;

    logic            accept;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic            oob;
    logic [AW-1:0]   word_idx;
    logic [3:0]      mask_base;
    logic [3:0]      byte_mask;
    logic [31:0]     rd_word;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign dBus_cmd_ready = cmd_ready_q;
    assign accept         = dBus_cmd_valid & cmd_ready_q;
    assign word_idx       = dBus_cmd_payload_address[AW+1:2];

`ifdef VEX_DBUS_RESP_ERROR_EN
    assign oob = |dBus_cmd_payload_address[31:AW+2];
`else
    // Upper bits alias onto the memory window.
    logic unused_addr_hi;
    assign unused_addr_hi = ^dBus_cmd_payload_address[31:AW+2];
    assign oob            = 1'b0;
`endif

    // Lanes shifted past byte 3 fall off the 4-bit mask (truncation).
    always_comb begin
        unique case (dBus_cmd_payload_size)
            2'd0:    mask_base = 4'b0001;
            2'd1:    mask_base = 4'b0011;
            default: mask_base = 4'b1111;
        endcase
    end
    assign byte_mask = mask_base << dBus_cmd_payload_address[1:0];

    assign wr_en   = accept & dBus_cmd_payload_wr & ~oob;
    assign push    = accept & ~dBus_cmd_payload_wr;
    assign rd_word = oob ? 32'h0 : mem[word_idx];

    assign pop = (count != '0) && (fifo_age[rd_ptr] >= LAT) && !rsp_stall;

    assign dBus_rsp_ready = pop;
    assign dBus_rsp_data  = pop ? fifo_data[rd_ptr] : 32'h0;
    assign dBus_rsp_error = pop ? fifo_err[rd_ptr] : 1'b0;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= dBus_cmd_payload_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            cmd_ready_q <= 1'b0;
            for (int i = 0; i < MAX_PENDING; i++) begin
                fifo_data[i] <= 32'h0;
                fifo_err[i]  <= 1'b0;
                fifo_age[i]  <= 4'd0;
            end
        end else begin
            for (int i = 0; i < MAX_PENDING; i++) begin
                if (fifo_age[i] < LAT) begin
                    fifo_age[i] <= fifo_age[i] + 4'd1;
                end
            end
            if (push) begin
                fifo_data[wr_ptr] <= rd_word;
                fifo_err[wr_ptr]  <= oob;
                // The acceptance edge already counts as one cycle of age.
                fifo_age[wr_ptr]  <= 4'd1;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count       <= count_next;
            // Registered so a pop this cycle only raises ready next cycle.
            cmd_ready_q <= (count_next < MAX_CNT);
        end
    end

endmodule

// File: tb/tb_vex_dbus_responder.sv
module tb_vex_dbus_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 1;
    localparam int MAXP  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dBus_cmd_valid = 1'b0;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr = 1'b0;
    logic [31:0] dBus_cmd_payload_address = 32'h0;
    logic [31:0] dBus_cmd_payload_data = 32'h0;
    logic [1:0]  dBus_cmd_payload_size = 2'd2;
    logic        dBus_rsp_ready;
    logic [31:0] dBus_rsp_data;
    logic        dBus_rsp_error;
    logic        rsp_stall = 1'b0;

    vex_dbus_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .dBus_cmd_valid          (dBus_cmd_valid),
        .dBus_cmd_ready          (dBus_cmd_ready),
        .dBus_cmd_payload_wr     (dBus_cmd_payload_wr),
        .dBus_cmd_payload_address(dBus_cmd_payload_address),
        .dBus_cmd_payload_data   (dBus_cmd_payload_data),
        .dBus_cmd_payload_size   (dBus_cmd_payload_size),
        .dBus_rsp_ready          (dBus_rsp_ready),
        .dBus_rsp_data           (dBus_rsp_data),
        .dBus_rsp_error          (dBus_rsp_error),
        .rsp_stall               (rsp_stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } rsp_t;

    logic [31:0] ref_mem [DEPTH];
    rsp_t        q [$];
    bit          armed = 1'b0;

    // Ready comes up one edge after reset is seen low.
    always @(posedge clk) armed = !reset;

    bit   exp_ready;
    bit   exp_rsp;
    int   m_idx;
    bit   m_oob;
    int   m_lo;
    int   m_hi;
    int   m_sz;
    rsp_t m_ent;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            armed = 1'b0;
            check("reset_cmd_ready", dBus_cmd_ready, 0);
            check("reset_rsp_ready", dBus_rsp_ready, 0);
            check("reset_rsp_data", dBus_rsp_data, 0);
            check("reset_rsp_error", dBus_rsp_error, 0);
        end else begin
            exp_ready = armed && (q.size() < MAXP);
            exp_rsp   = (q.size() > 0) && (q[0].due <= cyc) && !rsp_stall;
            check("cmd_ready", dBus_cmd_ready, exp_ready);
            check("rsp_ready", dBus_rsp_ready, exp_rsp);
            if (exp_rsp) begin
                check("rsp_data", dBus_rsp_data, q[0].data);
                check("rsp_error", dBus_rsp_error, q[0].err);
                void'(q.pop_front());
            end else begin
                check("idle_rsp_data", dBus_rsp_data, 0);
                check("idle_rsp_error", dBus_rsp_error, 0);
            end
            if (dBus_cmd_valid && exp_ready) begin
                m_idx = int'((dBus_cmd_payload_address >> 2) % DEPTH);
`ifdef VEX_DBUS_RESP_ERROR_EN
                m_oob = (dBus_cmd_payload_address >> 2) >= DEPTH;
`else
                m_oob = 1'b0;
`endif
                if (dBus_cmd_payload_wr) begin
                    m_sz = (dBus_cmd_payload_size == 2'd3) ? 2 : int'(dBus_cmd_payload_size);
                    m_lo = int'(dBus_cmd_payload_address[1:0]);
                    m_hi = m_lo + (1 << m_sz);
                    if (!m_oob) begin
                        for (int b = 0; b < 4; b++) begin
                            if (b >= m_lo && b < m_hi) begin
                                ref_mem[m_idx][8*b +: 8] = dBus_cmd_payload_data[8*b +: 8];
                            end
                        end
                    end
                end else begin
                    m_ent.data = m_oob ? 32'h0 : ref_mem[m_idx];
                    m_ent.err  = m_oob;
                    m_ent.due  = cyc + LAT;
                    q.push_back(m_ent);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size, output int acc);
        int n;
        n = 0;
        dBus_cmd_valid           = 1'b1;
        dBus_cmd_payload_wr      = wr;
        dBus_cmd_payload_address = addr;
        dBus_cmd_payload_data    = data;
        dBus_cmd_payload_size    = size;
        @(negedge clk);
        while (dBus_cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: ready stayed %b, required 1", dBus_cmd_ready);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        dBus_cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] exp_data, input int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (dBus_rsp_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, dBus_rsp_ready, 1);
        check({name, "_data"}, dBus_rsp_data, exp_data);
        check({name, "_latency"}, 32'(cyc - acc), LAT);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    int          acc;
    int          pulses;
    logic [31:0] ra;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Give every word a defined value.
        for (int w = 0; w < DEPTH; w++) begin
            send(1'b1, 32'(w * 4), $urandom, 2'd2, acc);
        end

        // Sequential write then read.
        send(1'b1, 32'h10, 32'h1122_3344, 2'd2, acc);
        send(1'b0, 32'h10, 32'h0, 2'd2, acc);
        expect_rsp("wr_rd", 32'h1122_3344, acc);

        // Byte-lane merge.
        send(1'b1, 32'h13, 32'hAA00_0000, 2'd0, acc);
        check("model_pin_merge", ref_mem[4], 32'hAA22_3344);
        send(1'b0, 32'h10, 32'h0, 2'd2, acc);
        expect_rsp("merge", 32'hAA22_3344, acc);

        // Halfword at offset 2, word at offset 1 (truncated mask).
        send(1'b1, 32'h40, 32'h0000_0000, 2'd2, acc);
        send(1'b1, 32'h42, 32'hBEEF_0000, 2'd1, acc);
        send(1'b1, 32'h41, 32'h1234_5600, 2'd3, acc);
        send(1'b0, 32'h40, 32'h0, 2'd2, acc);
        expect_rsp("mask_trunc", 32'h1234_5600, acc);

        // Upper address bits: error window or aliasing.
        send(1'b1, 32'h0, 32'h5566_7788, 2'd2, acc);
        send(1'b1, 32'h400, 32'h99AA_BBCC, 2'd2, acc);
        send(1'b0, 32'h0, 32'h0, 2'd2, acc);
`ifdef VEX_DBUS_RESP_ERROR_EN
        expect_rsp("oob_wr_dropped", 32'h5566_7788, acc);
        send(1'b0, 32'h400, 32'h0, 2'd2, acc);
        @(negedge clk);
        check("oob_rd_error", dBus_rsp_error, 1);
        check("oob_rd_data", dBus_rsp_data, 0);
        @(posedge clk);
        #1;
`else
        expect_rsp("alias_wr", 32'h99AA_BBCC, acc);
`endif

        // Backpressure and full push/pop.
        send(1'b1, 32'h20, 32'hCAFE_F00D, 2'd2, acc);
        send(1'b1, 32'h30, 32'h0BAD_BEEF, 2'd2, acc);
        rsp_stall = 1'b1;
        send(1'b0, 32'h10, 32'h0, 2'd2, acc);
        send(1'b0, 32'h20, 32'h0, 2'd2, acc);
        dBus_cmd_valid           = 1'b1;
        dBus_cmd_payload_wr      = 1'b0;
        dBus_cmd_payload_address = 32'h30;
        dBus_cmd_payload_size    = 2'd2;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", dBus_cmd_ready, 0);
            check("bp_no_rsp", dBus_rsp_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp_stall = 1'b0;
        @(negedge clk);
        check("bp_rsp1_ready", dBus_rsp_ready, 1);
        check("bp_rsp1_data", dBus_rsp_data, 32'hAA22_3344);
        check("full_pushpop_ready", dBus_cmd_ready, 0);
        @(negedge clk);
        check("bp_rsp2_ready", dBus_rsp_ready, 1);
        check("bp_rsp2_data", dBus_rsp_data, 32'hCAFE_F00D);
        check("bp_ready_back", dBus_cmd_ready, 1);
        @(posedge clk);
        #1;
        dBus_cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_rsp3_ready", dBus_rsp_ready, 1);
        check("bp_rsp3_data", dBus_rsp_data, 32'h0BAD_BEEF);
        @(posedge clk);
        #1;

        // Reset with two reads pending.
        rsp_stall = 1'b1;
        send(1'b0, 32'h10, 32'h0, 2'd2, acc);
        send(1'b0, 32'h20, 32'h0, 2'd2, acc);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        rsp_stall = 1'b0;
        pulses    = 0;
        repeat (10) begin
            @(negedge clk);
            if (dBus_rsp_ready === 1'b1) pulses++;
        end
        check("rst_no_rsp", 32'(pulses), 0);
        @(posedge clk);
        #1;
        send(1'b0, 32'h10, 32'h0, 2'd2, acc);
        expect_rsp("post_rst", 32'hAA22_3344, acc);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 600; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) != 0) ra[31:10] = '0;
            dBus_cmd_valid           = ($urandom_range(0, 3) != 0);
            dBus_cmd_payload_wr      = ($urandom_range(0, 2) == 0);
            dBus_cmd_payload_address = ra;
            dBus_cmd_payload_data    = $urandom;
            dBus_cmd_payload_size    = 2'($urandom_range(0, 3));
            rsp_stall                = ($urandom_range(0, 3) == 0);
            reset                    = (i >= 300 && i < 302);
            @(posedge clk);
            #1;
        end
        dBus_cmd_valid = 1'b0;
        rsp_stall      = 1'b0;
        reset          = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
